// File: rtl/clock_set_controller_pkg.sv
// Shared definitions for the clock time-set sequencer and the display scanner.
//   state_t      : FSM state codes, also driven out on the mode port
//   HOUR_MAX/MIN_MAX : BCD wrap limits for the 12-hour clock
//   MASK_*       : blink_mask bit positions (1 = blank that digit)
package clock_set_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_COMMIT  = 2'd3
  } state_t;

  localparam logic [7:0] HOUR_MAX = 8'h11;
  localparam logic [7:0] MIN_MAX  = 8'h59;

  localparam int unsigned DEB_W     = 20;
  localparam int unsigned BLINK_W   = 25;
  localparam int unsigned TIMEOUT_W = 32;

  localparam int unsigned MASK_W     = 6;
  localparam int unsigned MASK_SEC1  = 0;
  localparam int unsigned MASK_SEC2  = 1;
  localparam int unsigned MASK_MIN1  = 2;
  localparam int unsigned MASK_MIN2  = 3;
  localparam int unsigned MASK_HOUR1 = 4;
  localparam int unsigned MASK_HOUR2 = 5;

endpackage

// File: rtl/clock_set_controller_button_debounce.sv
// Button debouncer: 2-FF synchroniser, stable-level counter, press pulse.
//   clk, reset : system clock, synchronous active-high reset
//   btn        : raw asynchronous button level
//   press      : one-cycle pulse when the stable level goes 0 -> 1
module button_debounce
  import clock_set_controller_pkg::*;
#(
  parameter logic [DEB_W-1:0] CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic [1:0]       r_sync;
  logic             r_stable;
  logic [DEB_W-1:0] r_cnt;
  logic             r_press;

  logic w_differ;
  logic w_accept;

  // A new level is accepted on the CYCLES-th consecutive differing sample.
  assign w_differ = r_sync[1] != r_stable;
  assign w_accept = w_differ && (r_cnt == CYCLES - DEB_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync   <= 2'b00;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], btn};
      r_press <= w_accept && r_sync[1];
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt    <= '0;
        r_stable <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + DEB_W'(1);
      end
    end
  end

  assign press = r_press;

endmodule

// File: rtl/clock_set_controller.sv
// Time-set sequencer for the 12-hour clock counter.
//   clk, reset           : system clock, synchronous active-high reset
//   btn_mode, btn_inc    : raw buttons
//   cur_hour, cur_min    : live BCD time from the counter
//   run_en               : counter enable (RUN only)
//   load, load_hour/min  : one-cycle parallel load of the edited time
//   disp_hour, disp_min  : value for the display scanner
//   blink_mask           : per-digit blank mask for the digits being edited
//   mode                 : current state code
module clock_set_controller
  import clock_set_controller_pkg::*;
#(
  parameter logic [DEB_W-1:0]     DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [BLINK_W-1:0]   BLINK_DIV       = 25'd12500000,
  parameter logic [TIMEOUT_W-1:0] SET_TIMEOUT     = 32'd500000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic [7:0]  cur_hour,
  input  logic [7:0]  cur_min,
  output logic        run_en,
  output logic        load,
  output logic [7:0]  load_hour,
  output logic [7:0]  load_min,
  output logic [7:0]  disp_hour,
  output logic [7:0]  disp_min,
  output logic [5:0]  blink_mask,
  output logic [1:0]  mode
);

  // BCD +1 that wraps to 00 after vmax; x9 carries into the tens nibble.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
    logic [7:0] r;
    if (v == vmax)            r = 8'h00;
    else if (v[3:0] == 4'h9)  r = {v[7:4] + 4'h1, 4'h0};
    else                      r = {v[7:4], v[3:0] + 4'h1};
    return r;
  endfunction

  logic w_mode_p;
  logic w_inc_p;

  button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
    .clk(clk), .reset(reset), .btn(btn_mode), .press(w_mode_p)
  );

  button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
    .clk(clk), .reset(reset), .btn(btn_inc), .press(w_inc_p)
  );

  state_t               r_state;
  logic [7:0]           r_shadow_hour;
  logic [7:0]           r_shadow_min;
  logic [TIMEOUT_W-1:0] r_timer;
  logic [BLINK_W-1:0]   r_blink_cnt;
  logic                 r_phase;
  logic                 r_run_en;
  logic                 r_load;
  logic [7:0]           r_load_hour;
  logic [7:0]           r_load_min;
  logic [7:0]           r_disp_hour;
  logic [7:0]           r_disp_min;
  logic [MASK_W-1:0]    r_blink_mask;

  state_t               w_state_n;
  logic [7:0]           w_shadow_hour_n;
  logic [7:0]           w_shadow_min_n;
  logic [TIMEOUT_W-1:0] w_timer_n;
  logic                 w_enter_hr;
  logic [BLINK_W-1:0]   w_blink_cnt_n;
  logic                 w_phase_n;
  logic [MASK_W-1:0]    w_mask_n;
  logic                 w_timeout;

  assign w_timeout = r_timer == SET_TIMEOUT - TIMEOUT_W'(1);

  // Next state, shadow edits and idle timer; mode press beats inc press.
  always_comb begin
    w_state_n       = r_state;
    w_shadow_hour_n = r_shadow_hour;
    w_shadow_min_n  = r_shadow_min;
    w_timer_n       = '0;
    w_enter_hr      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mode_p) begin
          w_state_n       = ST_SET_HR;
          w_shadow_hour_n = cur_hour;
          w_shadow_min_n  = cur_min;
          w_enter_hr      = 1'b1;
        end
      end
      ST_SET_HR: begin
        if (w_mode_p)        w_state_n = ST_SET_MIN;
        else if (w_inc_p)    w_shadow_hour_n = bcd_inc(r_shadow_hour, HOUR_MAX);
        else if (w_timeout)  w_state_n = ST_RUN;
        else                 w_timer_n = r_timer + TIMEOUT_W'(1);
      end
      ST_SET_MIN: begin
        if (w_mode_p)        w_state_n = ST_COMMIT;
        else if (w_inc_p)    w_shadow_min_n = bcd_inc(r_shadow_min, MIN_MAX);
        else if (w_timeout)  w_state_n = ST_RUN;
        else                 w_timer_n = r_timer + TIMEOUT_W'(1);
      end
      default: w_state_n = ST_RUN;
    endcase
  end

  // Free-running blink phase, restarted whenever editing begins.
  always_comb begin
    w_blink_cnt_n = r_blink_cnt + BLINK_W'(1);
    w_phase_n     = r_phase;
    if (w_enter_hr) begin
      w_blink_cnt_n = '0;
      w_phase_n     = 1'b0;
    end else if (r_blink_cnt == BLINK_DIV - BLINK_W'(1)) begin
      w_blink_cnt_n = '0;
      w_phase_n     = ~r_phase;
    end
  end

  // Blank the pair of digits currently being edited during the phase-1 half.
  always_comb begin
    w_mask_n = '0;
    if (w_state_n == ST_SET_HR) begin
      w_mask_n[MASK_HOUR2] = w_phase_n;
      w_mask_n[MASK_HOUR1] = w_phase_n;
    end else if (w_state_n == ST_SET_MIN) begin
      w_mask_n[MASK_MIN2] = w_phase_n;
      w_mask_n[MASK_MIN1] = w_phase_n;
    end
  end

  // State, timers and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_shadow_hour <= 8'h00;
      r_shadow_min  <= 8'h00;
      r_timer       <= '0;
      r_blink_cnt   <= '0;
      r_phase       <= 1'b0;
      r_run_en      <= 1'b1;
      r_load        <= 1'b0;
      r_load_hour   <= 8'h00;
      r_load_min    <= 8'h00;
      r_disp_hour   <= cur_hour;
      r_disp_min    <= cur_min;
      r_blink_mask  <= '0;
    end else begin
      r_state       <= w_state_n;
      r_shadow_hour <= w_shadow_hour_n;
      r_shadow_min  <= w_shadow_min_n;
      r_timer       <= w_timer_n;
      r_blink_cnt   <= w_blink_cnt_n;
      r_phase       <= w_phase_n;
      r_run_en      <= w_state_n == ST_RUN;
      r_load        <= w_state_n == ST_COMMIT;
      r_load_hour   <= w_shadow_hour_n;
      r_load_min    <= w_shadow_min_n;
      r_disp_hour   <= (w_state_n == ST_RUN) ? cur_hour : w_shadow_hour_n;
      r_disp_min    <= (w_state_n == ST_RUN) ? cur_min  : w_shadow_min_n;
      r_blink_mask  <= w_mask_n;
    end
  end

  assign run_en     = r_run_en;
  assign load       = r_load;
  assign load_hour  = r_load_hour;
  assign load_min   = r_load_min;
  assign disp_hour  = r_disp_hour;
  assign disp_min   = r_disp_min;
  assign blink_mask = r_blink_mask;
  assign mode       = r_state;

endmodule

// File: tb/tb_clock_set_controller.sv
// Self-checking bench for clock_set_controller with short timing parameters.
module tb_clock_set_controller;

  localparam logic [19:0] DEB = 20'd4;
  localparam logic [24:0] BL  = 25'd8;
  localparam logic [31:0] TO  = 32'd64;
  localparam int DEB_I = 4;
  localparam int BL_I  = 8;
  localparam int TO_I  = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_inc;
  logic [7:0] cur_hour, cur_min;
  logic       run_en, load;
  logic [7:0] load_hour, load_min, disp_hour, disp_min;
  logic [5:0] blink_mask;
  logic [1:0] mode;

  always #5 clk = ~clk;

  clock_set_controller #(
    .DEBOUNCE_CYCLES(DEB), .BLINK_DIV(BL), .SET_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hour(cur_hour), .cur_min(cur_min), .run_en(run_en), .load(load),
    .load_hour(load_hour), .load_min(load_min), .disp_hour(disp_hour),
    .disp_min(disp_min), .blink_mask(blink_mask), .mode(mode)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: times held as plain integers, debounce as a sample window.
  int         m_mode, m_sh, m_sm, m_idle, m_t, m_n;
  bit         m_stab [2];
  bit         m_pend [2];
  bit         raw_log [2][64];
  logic [7:0] m_disp_h, m_disp_m;

  int         n_load = 0;
  logic [7:0] ld_h, ld_m;

  function automatic int dec(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  // Button level seen by the debouncer at edge n: raw level two edges earlier.
  function automatic bit delayed(input int b, input int n);
    if (n < 3) return 1'b0;
    return raw_log[b][(n - 2) % 64];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit mp;
    bit ip;
    bit all_diff;
    if (reset) begin
      m_mode = 0; m_sh = 0; m_sm = 0; m_idle = 0; m_t = 0; m_n = 0;
      m_stab = '{1'b0, 1'b0};
      m_pend = '{1'b0, 1'b0};
      m_disp_h = cur_hour;
      m_disp_m = cur_min;
      return;
    end
    mp = m_pend[0];
    ip = m_pend[1];
    m_t++;
    case (m_mode)
      0: if (mp) begin
           m_mode = 1; m_sh = dec(cur_hour); m_sm = dec(cur_min); m_idle = 0; m_t = 0;
         end
      1: if (mp) begin m_mode = 2; m_idle = 0; end
         else if (ip) begin m_sh = (m_sh + 1) % 12; m_idle = 0; end
         else begin
           m_idle++;
           if (m_idle == TO_I) begin m_mode = 0; m_idle = 0; end
         end
      2: if (mp) begin m_mode = 3; m_idle = 0; end
         else if (ip) begin m_sm = (m_sm + 1) % 60; m_idle = 0; end
         else begin
           m_idle++;
           if (m_idle == TO_I) begin m_mode = 0; m_idle = 0; end
         end
      default: begin m_mode = 0; m_idle = 0; end
    endcase
    m_n++;
    raw_log[0][m_n % 64] = btn_mode;
    raw_log[1][m_n % 64] = btn_inc;
    for (int b = 0; b < 2; b++) begin
      m_pend[b] = 1'b0;
      if (m_n >= DEB_I) begin
        all_diff = 1'b1;
        for (int j = 0; j < DEB_I; j++)
          if (delayed(b, m_n - j) == m_stab[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_stab[b] = !m_stab[b];
          m_pend[b] = m_stab[b];
        end
      end
    end
    m_disp_h = (m_mode == 0) ? cur_hour : bcd(m_sh);
    m_disp_m = (m_mode == 0) ? cur_min  : bcd(m_sm);
  endtask

  task automatic compare();
    logic [5:0] em;
    bit ph;
    ph = 1'((m_t / BL_I) % 2);
    em = 6'b0;
    if (m_mode == 1) em = {ph, ph, 4'b0000};
    if (m_mode == 2) em = {2'b00, ph, ph, 2'b00};
    chk("mode", 32'(mode), 32'(m_mode));
    chk("run_en", 32'(run_en), 32'(m_mode == 0));
    chk("load", 32'(load), 32'(m_mode == 3));
    chk("blink_mask", 32'(blink_mask), 32'(em));
    chk("disp_hour", 32'(disp_hour), 32'(m_disp_h));
    chk("disp_min", 32'(disp_min), 32'(m_disp_m));
    if (m_mode == 3) begin
      chk("load_hour", 32'(load_hour), 32'(bcd(m_sh)));
      chk("load_min", 32'(load_min), 32'(bcd(m_sm)));
    end
    if (load === 1'b1) begin
      n_load++;
      ld_h = load_hour;
      ld_m = load_min;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic press(input bit m, input bit i, input int hold, input int rel);
    btn_mode = m;
    btn_inc  = i;
    repeat (hold) tick();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (rel) tick();
  endtask

  typedef struct {
    bit         m;
    bit         i;
    int         hold;
    int         rel;
    logic [1:0] exp_mode;
    logic [7:0] exp_dh;
    logic [7:0] exp_dm;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int c;
    int nl;
    tbl[0] = '{1'b1, 1'b0, 3,  12, 2'd0, 8'h07, 8'h42};
    tbl[1] = '{1'b1, 1'b0, 10, 6,  2'd1, 8'h07, 8'h42};
    tbl[2] = '{1'b0, 1'b1, 10, 6,  2'd1, 8'h08, 8'h42};
    tbl[3] = '{1'b1, 1'b0, 10, 6,  2'd2, 8'h08, 8'h42};
    tbl[4] = '{1'b0, 1'b1, 10, 6,  2'd2, 8'h08, 8'h43};
    tbl[5] = '{1'b1, 1'b0, 10, 6,  2'd0, 8'h07, 8'h42};

    reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    cur_hour = 8'h07; cur_min = 8'h42;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_run_en", 32'(run_en), 32'd1);
    chk("reset_mask", 32'(blink_mask), 32'd0);
    chk("reset_disp_hour", 32'(disp_hour), 32'h07);
    chk("reset_disp_min", 32'(disp_min), 32'h42);

    // Glitch, then a full edit 07:42 -> 08:43 and commit.
    nl = n_load;
    foreach (tbl[k]) begin
      press(tbl[k].m, tbl[k].i, tbl[k].hold, tbl[k].rel);
      chk($sformatf("row%0d_mode", k), 32'(mode), 32'(tbl[k].exp_mode));
      chk($sformatf("row%0d_disp_hour", k), 32'(disp_hour), 32'(tbl[k].exp_dh));
      chk($sformatf("row%0d_disp_min", k), 32'(disp_min), 32'(tbl[k].exp_dm));
    end
    chk("row_load_count", 32'(n_load - nl), 32'd1);
    chk("row_load_hour", 32'(ld_h), 32'h08);
    chk("row_load_min", 32'(ld_m), 32'h43);

    // Idle timeout in SET_HR: exactly TO cycles after entry, no load.
    nl = n_load;
    btn_mode = 1'b1;
    c = 0;
    while (mode !== 2'd1 && c < 20) begin tick(); c++; end
    chk("timeout_entry", 32'(mode), 32'd1);
    c = 0;
    while (mode !== 2'd0 && c < 200) begin
      tick();
      c++;
      if (c == 5) btn_mode = 1'b0;
    end
    chk("timeout_cycles", 32'(c), 32'(TO_I));
    chk("timeout_no_load", 32'(n_load - nl), 32'd0);
    chk("timeout_run_en", 32'(run_en), 32'd1);

    // Wrap edits from 11:58 and commit 00:00.
    cur_hour = 8'h11; cur_min = 8'h58;
    tick();
    press(1'b1, 1'b0, 10, 6);
    chk("wrap_disp_hour0", 32'(disp_hour), 32'h11);
    press(1'b0, 1'b1, 10, 6);
    chk("wrap_hour", 32'(disp_hour), 32'h00);
    press(1'b1, 1'b0, 10, 6);
    press(1'b0, 1'b1, 10, 6);
    chk("wrap_min59", 32'(disp_min), 32'h59);
    press(1'b0, 1'b1, 10, 6);
    chk("wrap_min00", 32'(disp_min), 32'h00);
    nl = n_load;
    press(1'b1, 1'b0, 10, 6);
    chk("wrap_load_count", 32'(n_load - nl), 32'd1);
    chk("wrap_load_hour", 32'(ld_h), 32'h00);
    chk("wrap_load_min", 32'(ld_m), 32'h00);
    chk("wrap_back_run", 32'(mode), 32'd0);

    // Simultaneous MODE and INC in SET_HR: mode wins.
    press(1'b1, 1'b0, 10, 6);
    press(1'b1, 1'b1, 10, 6);
    chk("simul_mode", 32'(mode), 32'd2);
    chk("simul_hour", 32'(disp_hour), 32'h11);
    press(1'b1, 1'b0, 10, 6);

    // Reset mid-edit discards the edit without a load.
    press(1'b1, 1'b0, 10, 6);
    press(1'b1, 1'b0, 10, 6);
    press(1'b0, 1'b1, 10, 6);
    press(1'b0, 1'b1, 10, 6);
    chk("pre_reset_mode", 32'(mode), 32'd2);
    nl = n_load;
    reset = 1'b1;
    tick();
    chk("midreset_mode", 32'(mode), 32'd0);
    chk("midreset_load", 32'(load), 32'd0);
    chk("midreset_run_en", 32'(run_en), 32'd1);
    reset = 1'b0;
    repeat (4) tick();
    chk("midreset_no_load", 32'(n_load - nl), 32'd0);

    // Randomised buttons, time values and occasional resets.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      btn_mode = ($urandom_range(0, 2) == 0);
      btn_inc  = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 7) == 0) begin
        cur_hour = bcd(int'($urandom_range(0, 11)));
        cur_min  = bcd(int'($urandom_range(0, 59)));
      end
      repeat ($urandom_range(1, 14)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
